// File: rtl/neuron_layer_sequencer.sv
// Sequences one shared serial MAC neuron across all rows of a dense layer:
// fetch weight row and bias, issue one MAC op per neuron, collect results into y_flat.
module neuron_layer_sequencer #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned NUM_INPUTS  = 8,
    parameter int unsigned X_W         = 8,
    parameter int unsigned W_W         = 8,
    parameter int unsigned B_W         = 32,
    parameter int unsigned OUT_W       = 16,
    parameter int unsigned AW          = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [NUM_INPUTS*X_W-1:0]         x_flat,
    output logic                              busy,
    output logic                              done,
    output logic [NUM_NEURONS*OUT_W-1:0]      y_flat,
    output logic [AW:0]                       sat_cnt,
    output logic                              mem_rd_en,
    output logic [AW-1:0]                     mem_addr,
    input  logic [NUM_INPUTS*W_W-1:0]         w_rdata,
    input  logic [B_W-1:0]                    b_rdata,
    output logic                              mac_in_valid,
    input  logic                              mac_in_ready,
    output logic [NUM_INPUTS*X_W-1:0]         mac_x_flat,
    output logic [NUM_INPUTS*W_W-1:0]         mac_w_flat,
    output logic [B_W-1:0]                    mac_bias,
    input  logic                              mac_out_valid,
    input  logic [OUT_W-1:0]                  mac_out_data
);

    localparam int unsigned XF_W = NUM_INPUTS * X_W;
    localparam int unsigned WF_W = NUM_INPUTS * W_W;
    localparam int unsigned YF_W = NUM_NEURONS * OUT_W;
    localparam int unsigned SC_W = AW + 1;
    localparam logic [AW-1:0]    LAST_IDX = AW'(NUM_NEURONS - 1);
    localparam logic [OUT_W-1:0] SAT_POS  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG  = {1'b1, {(OUT_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RDWAIT,
        S_ISSUE,
        S_WAIT_RES
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [XF_W-1:0]   x_q, x_d;
    logic [WF_W-1:0]   w_q, w_d;
    logic [B_W-1:0]    b_q, b_d;
    logic [YF_W-1:0]   y_q, y_d;
    logic [SC_W-1:0]   sat_q, sat_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rd_en_q, rd_en_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              in_valid_q, in_valid_d;
    logic              is_sat;

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            x_q        <= '0;
            w_q        <= '0;
            b_q        <= '0;
            y_q        <= '0;
            sat_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            addr_q     <= '0;
            in_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            x_q        <= x_d;
            w_q        <= w_d;
            b_q        <= b_d;
            y_q        <= y_d;
            sat_q      <= sat_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            addr_q     <= addr_d;
            in_valid_q <= in_valid_d;
        end
    end

    // Next-state logic; abort overrides everything outside IDLE, so a result in the same cycle is dropped
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        w_d     = w_q;
        b_d     = b_q;
        y_d     = y_q;
        sat_d   = sat_q;
        done_d  = 1'b0;
        is_sat  = (mac_out_data == SAT_POS) || (mac_out_data == SAT_NEG);

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        x_d     = x_flat;
                        y_d     = '0;
                        sat_d   = '0;
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end
                end
                S_FETCH: begin
                    state_d = S_RDWAIT;
                end
                S_RDWAIT: begin
                    w_d     = w_rdata;
                    b_d     = b_rdata;
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (in_valid_q && mac_in_ready) begin
                        state_d = S_WAIT_RES;
                    end
                end
                S_WAIT_RES: begin
                    if (mac_out_valid) begin
                        for (int unsigned k = 0; k < NUM_NEURONS; k++) begin
                            if (idx_q == AW'(k)) begin
                                y_d[k*OUT_W +: OUT_W] = mac_out_data;
                            end
                        end
                        if (is_sat) begin
                            sat_d = sat_q + SC_W'(1);
                        end
                        if (idx_q == LAST_IDX) begin
                            done_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_q + AW'(1);
                            state_d = S_FETCH;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d     = (state_d != S_IDLE);
        rd_en_d    = (state_d == S_FETCH);
        in_valid_d = (state_d == S_ISSUE);
        addr_d     = (state_d == S_FETCH) ? idx_d : addr_q;
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign y_flat       = y_q;
    assign sat_cnt      = sat_q;
    assign mem_rd_en    = rd_en_q;
    assign mem_addr     = addr_q;
    assign mac_in_valid = in_valid_q;
    assign mac_x_flat   = x_q;
    assign mac_w_flat   = w_q;
    assign mac_bias     = b_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench: table of whole-layer cases plus hand sequences for abort/restart, ignored start and reset.
module tb_neuron_layer_sequencer;

    localparam int unsigned NN = 4;
    localparam int unsigned NI = 8;
    localparam int unsigned AW = 2;

    logic                clk;
    logic                rst;
    logic                start;
    logic                abort;
    logic [NI*8-1:0]     x_flat;
    logic                busy;
    logic                done;
    logic [NN*16-1:0]    y_flat;
    logic [AW:0]         sat_cnt;
    logic                mem_rd_en;
    logic [AW-1:0]       mem_addr;
    logic [NI*8-1:0]     w_rdata;
    logic [31:0]         b_rdata;
    logic                mac_in_valid;
    logic                mac_in_ready;
    logic [NI*8-1:0]     mac_x_flat;
    logic [NI*8-1:0]     mac_w_flat;
    logic [31:0]         mac_bias;
    logic                mac_out_valid;
    logic [15:0]         mac_out_data;

    neuron_layer_sequencer #(
        .NUM_NEURONS(NN), .NUM_INPUTS(NI), .X_W(8), .W_W(8),
        .B_W(32), .OUT_W(16), .AW(AW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x_flat(x_flat),
        .busy(busy), .done(done), .y_flat(y_flat), .sat_cnt(sat_cnt),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .w_rdata(w_rdata), .b_rdata(b_rdata),
        .mac_in_valid(mac_in_valid), .mac_in_ready(mac_in_ready),
        .mac_x_flat(mac_x_flat), .mac_w_flat(mac_w_flat), .mac_bias(mac_bias),
        .mac_out_valid(mac_out_valid), .mac_out_data(mac_out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Weight/bias memories with one-cycle synchronous read
    logic [NI*8-1:0] wmem [NN];
    logic [31:0]     bmem [NN];
    always @(posedge clk) begin
        if (mem_rd_en) begin
            w_rdata <= wmem[mem_addr];
            b_rdata <= bmem[mem_addr];
        end
    end

    // Serial MAC model: result pulse NI+1 cycles after accept, saturated to 16 bits
    function automatic logic [15:0] mac_f(input logic [NI*8-1:0] xf, input logic [NI*8-1:0] wf,
                                          input logic [31:0] bb);
        longint acc;
        acc = longint'($signed(bb));
        for (int i = 0; i < NI; i++)
            acc += longint'($signed(xf[i*8 +: 8])) * longint'($signed(wf[i*8 +: 8]));
        if (acc > 32767) return 16'h7FFF;
        if (acc < -32768) return 16'h8000;
        return acc[15:0];
    endfunction

    int          mac_cnt;
    logic [15:0] mac_res;
    logic        hold;
    initial begin
        mac_cnt = 0;
        mac_res = '0;
    end
    always @(posedge clk) begin
        if (mac_in_valid && mac_in_ready) begin
            mac_cnt <= NI + 1;
            mac_res <= mac_f(mac_x_flat, mac_w_flat, mac_bias);
        end else if (mac_cnt != 0) begin
            mac_cnt <= mac_cnt - 1;
        end
    end
    assign mac_in_ready  = (mac_cnt == 0) && !hold;
    assign mac_out_valid = (mac_cnt == 1);
    assign mac_out_data  = mac_res;

    int checks;
    int errors;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic load_mem(input logic [31:0] w, input logic [127:0] b);
        for (int k = 0; k < NN; k++) begin
            wmem[k] = {NI{w[k*8 +: 8]}};
            bmem[k] = b[k*32 +: 32];
        end
    endtask

    typedef struct {
        logic [7:0]   x;
        logic [31:0]  w;
        logic [127:0] b;
        int           stall;
        logic [63:0]  ey;
        logic [2:0]   esat;
        int           edone;
    } case_t;

    case_t       tbl [4];
    int          got;
    int          st;
    logic [63:0] ow;
    logic [31:0] ob;

    initial begin
        checks = 0;
        errors = 0;
        // x, weight per row (slot0 low), bias per row, ISSUE stall, expected y, sat, done cycle
        tbl[0] = '{8'd1,   32'h0302_0100, 128'd0, 0, 64'h0018_0010_0008_0000, 3'd0, 49};
        tbl[1] = '{8'd1,   32'h0302_0100, 128'd0, 5, 64'h0018_0010_0008_0000, 3'd0, 54};
        tbl[2] = '{8'd127, 32'h807F_0001, 128'h00000000_00000000_00000005_FFFFFFF0,
                   0, 64'h8000_7FFF_0005_03E8, 3'd2, 49};
        tbl[3] = '{8'd0,   32'h0000_0000, 128'hFFFFFFFF_00000064_FFFF8000_00007FFF,
                   0, 64'hFFFF_0064_8000_7FFF, 3'd2, 49};

        rst = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; x_flat = '0;
        load_mem(32'd0, 128'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_y", y_flat, 64'd0);
        chk("reset_valid_rd", {mac_in_valid, mem_rd_en, mem_addr, sat_cnt}, 0);

        for (int i = 0; i < 4; i++) begin
            st = tbl[i].stall;
            load_mem(tbl[i].w, tbl[i].b);
            hold = (st != 0);
            @(negedge clk);
            x_flat = {NI{tbl[i].x}};
            start  = 1'b1;
            got    = -1;
            for (int c = 1; c <= 120; c++) begin
                @(negedge clk);
                start = 1'b0;
                if (c == 3 + st) hold = 1'b0;
                if (c == 1) chk($sformatf("c%0d_rd_en_c1", i), {busy, mem_rd_en, mem_addr}, 4'b1100);
                if (c == 2) chk($sformatf("c%0d_rd_en_c2", i), mem_rd_en, 1'b0);
                if (c == 3) begin
                    ow = mac_w_flat;
                    ob = mac_bias;
                    chk($sformatf("c%0d_issue_valid", i), mac_in_valid, 1'b1);
                end
                if (c > 3 && c < 3 + st) begin
                    chk($sformatf("c%0d_stall_valid_c%0d", i, c), mac_in_valid, 1'b1);
                    chk($sformatf("c%0d_stall_ops_c%0d", i, c), {mac_w_flat, mac_bias}, {ow, ob});
                end
                if (c == 13 + st) chk($sformatf("c%0d_fetch1", i), {mem_rd_en, mem_addr}, 3'b101);
                if (c == 24 + st) chk($sformatf("c%0d_slot1_early", i), y_flat[16 +: 16], 16'd0);
                if (c == 25 + st) chk($sformatf("c%0d_slot1", i), y_flat[16 +: 16], tbl[i].ey[16 +: 16]);
                if (got < 0 && done) begin
                    got = c;
                    chk($sformatf("c%0d_y", i), y_flat, tbl[i].ey);
                    chk($sformatf("c%0d_sat", i), sat_cnt, tbl[i].esat);
                    chk($sformatf("c%0d_busy_at_done", i), busy, 1'b0);
                end else if (got >= 0) begin
                    chk($sformatf("c%0d_done_pulse", i), done, 1'b0);
                    chk($sformatf("c%0d_y_hold", i), y_flat, tbl[i].ey);
                    break;
                end
            end
            chk($sformatf("c%0d_done_cycle", i), got, tbl[i].edone);
            repeat (3) @(negedge clk);
        end

        // Abort in WAIT_RES of neuron 1, immediate restart with a stray result pending
        load_mem(32'h0403_0201, 128'd0);
        @(negedge clk);
        x_flat = {NI{8'd1}};
        start  = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 17) chk("t3_in_wait_res", {busy, mac_in_valid}, 2'b10);
            if (done) chk("t3_no_early_done", done, 1'b0);
            if (c == 18) abort = 1'b1;
        end
        @(negedge clk);
        chk("t3_idle_after_abort", {busy, mac_in_valid, mem_rd_en, done}, 4'b0000);
        chk("t3_partial_y", y_flat, 64'h0000_0000_0000_0008);
        abort  = 1'b0;
        x_flat = {NI{8'd2}};
        start  = 1'b1;
        got    = -1;
        for (int r = 1; r <= 120; r++) begin
            @(negedge clk);
            start = 1'b0;
            if (r >= 3 && r <= 5) chk($sformatf("t3_stall_r%0d", r), {mac_in_valid, mac_in_ready}, 2'b10);
            if (r == 6) chk("t3_stray_dropped", y_flat, 64'd0);
            if (done) begin
                got = r;
                chk("t3_y", y_flat, 64'h0040_0030_0020_0010);
                chk("t3_sat", sat_cnt, 3'd0);
                break;
            end
        end
        chk("t3_done_cycle", got, 52);
        repeat (3) @(negedge clk);

        // start while busy is ignored
        @(negedge clk);
        x_flat = {NI{8'd1}};
        start  = 1'b1;
        got    = -1;
        for (int c = 1; c <= 120; c++) begin
            @(negedge clk);
            start = (c == 5);
            if (c == 5) x_flat = {NI{8'd3}};
            if (done) begin
                got = c;
                chk("t5_y", y_flat, 64'h0020_0018_0010_0008);
                break;
            end
        end
        start = 1'b0;
        chk("t5_done_cycle", got, 49);
        @(negedge clk);

        // start with abort in IDLE stays IDLE
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("t5_start_abort_idle", {busy, mem_rd_en}, 2'b00);
        @(negedge clk);
        chk("t5_start_abort_idle2", {busy, mem_rd_en}, 2'b00);

        // rst mid-layer returns everything to reset values
        x_flat = {NI{8'd1}};
        start  = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("t5_y_before_rst", y_flat[15:0], 16'd8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_rst_ctrl", {busy, done, mem_rd_en, mac_in_valid, mem_addr, sat_cnt}, 0);
        chk("t5_rst_y", y_flat, 64'd0);
        chk("t5_rst_ops", {mac_x_flat, mac_w_flat, mac_bias}, 0);
        repeat (12) @(negedge clk);
        chk("t5_idle_after_rst", {busy, y_flat}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
